multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle datapath: an IDLE/DECODE/EXECUTE/MEM/WRITEBACK FSM driving an 8-entry
// register file, a word-addressed data memory and BEQ branching on a PC_W-bit pc.
module multicycle_datapath #(
  parameter int DATA_W     = 16,
  parameter int DMEM_DEPTH = 64,
  parameter int PC_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              ovf,
  output logic              take_branch,
  output logic              illegal
);

  localparam int AW  = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK
  } state_e;

  state_e              state_q;
  logic [15:0]         instr_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   rf_q [8];
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic [DATA_W-1:0]   op_d_q;
  logic [DATA_W-1:0]   simm_q;
  logic [AW-1:0]       addr_q;
  logic                wb_valid_q;
  logic [2:0]          wb_addr_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                ovf_q;
  logic                take_branch_q;
  logic                illegal_q;
  logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];

  logic [3:0]          opcode;
  logic [2:0]          rd;
  logic [2:0]          rs1;
  logic [2:0]          rs2;
  logic [5:0]          imm6;
  logic [DATA_W-1:0]   simm;
  logic [PC_W-1:0]     simm_pc;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     pc_branch;
  logic [DATA_W-1:0]   sum_ab;
  logic [DATA_W-1:0]   diff_ab;
  logic [DATA_W-1:0]   sum_ai;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_ovf;
  logic                dmem_we;

  assign opcode = instr_q[15:12];
  assign rd     = instr_q[11:9];
  assign rs1    = instr_q[8:6];
  assign rs2    = instr_q[5:3];
  assign imm6   = instr_q[5:0];

  assign simm      = DATA_W'($signed(imm6));
  assign simm_pc   = PC_W'($signed(imm6));
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_branch = pc_q + PC_W'(1) + simm_pc;

  assign sum_ab  = op_a_q + op_b_q;
  assign diff_ab = op_a_q - op_b_q;
  assign sum_ai  = op_a_q + simm_q;

  // Overflow: operands agree in sign (after negating b for SUB) but the result does not.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = sum_ab;
        alu_ovf = (op_a_q[MSB] == op_b_q[MSB]) && (sum_ab[MSB] != op_a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = diff_ab;
        alu_ovf = (op_a_q[MSB] != op_b_q[MSB]) && (diff_ab[MSB] != op_a_q[MSB]);
      end
      OP_AND:  alu_res = op_a_q & op_b_q;
      OP_OR:   alu_res = op_a_q | op_b_q;
      OP_XOR:  alu_res = op_a_q ^ op_b_q;
      OP_ADDI: begin
        alu_res = sum_ai;
        alu_ovf = (op_a_q[MSB] == simm_q[MSB]) && (sum_ai[MSB] != op_a_q[MSB]);
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      pc_q          <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_d_q        <= '0;
      simm_q        <= '0;
      addr_q        <= '0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      ovf_q         <= 1'b0;
      take_branch_q <= 1'b0;
      illegal_q     <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      // NOTE: pulse outputs default low here so each one lasts exactly one cycle.
      wb_valid_q    <= 1'b0;
      ovf_q         <= 1'b0;
      take_branch_q <= 1'b0;
      illegal_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_a_q        <= rf_q[rs1];
          op_b_q        <= rf_q[rs2];
          op_d_q        <= rf_q[rd];
          simm_q        <= simm;
          take_branch_q <= (opcode == OP_BEQ) && (rf_q[rd] == rf_q[rs1]);
          illegal_q     <= (opcode > OP_BEQ);
          state_q       <= S_EXECUTE;
        end
        S_EXECUTE: begin
          wb_addr_q <= rd;
          if (opcode == OP_LW || opcode == OP_SW) begin
            addr_q  <= sum_ai[AW-1:0];
            state_q <= S_MEM;
          end else if (opcode >= OP_BEQ) begin
            pc_q    <= take_branch_q ? pc_branch : pc_inc;
            state_q <= S_IDLE;
          end else begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= alu_res;
            ovf_q      <= alu_ovf;
            state_q    <= S_WRITEBACK;
          end
        end
        S_MEM: begin
          if (opcode == OP_SW) begin
            pc_q    <= pc_inc;
            state_q <= S_IDLE;
          end else begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= dmem_q[addr_q];
            state_q    <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          if (wb_addr_q != 3'd0) rf_q[wb_addr_q] <= wb_data_q;
          pc_q    <= pc_inc;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem_we = (state_q == S_MEM) && (opcode == OP_SW);

  // NOTE: data memory has no reset so it maps onto plain RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (dmem_we) dmem_q[addr_q] <= op_d_q;
  end

  assign instr_ready = (state_q == S_IDLE);
  assign pc          = pc_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign ovf         = ovf_q;
  assign take_branch = take_branch_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed scenarios plus random instructions checked
// against an arithmetic reference model of registers, memory and pc.
module tb_multicycle_datapath;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  pc;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ovf;
  logic        take_branch;
  logic        illegal;

  multicycle_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .pc          (pc),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ovf         (ovf),
    .take_branch (take_branch),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    int          wb_cyc;
    logic [15:0] data;
    logic [2:0]  addr;
    logic        ovf;
    int          br;
    int          ill;
    logic [7:0]  pc_after;
  } exp_t;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_rf [8];
  logic [15:0] m_mem [64];
  bit          m_known [64];
  logic [7:0]  m_pc;

  int          last_wb_cyc;
  logic [15:0] last_wb_data;
  logic        last_wb_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rd, input int rs1, input logic [5:0] imm);
    return {4'(op), 3'(rd), 3'(rs1), imm};
  endfunction

  function automatic int to_s(input logic [15:0] v);
    return (int'(v) >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_pc = '0;
  endtask

  task automatic model_step(input logic [15:0] ins, output exp_t e);
    int op, rd, s, full, addr;
    logic [15:0] a, b, d, res;
    op = int'(ins[15:12]);
    rd = int'(ins[11:9]);
    s  = int'(ins[5:0]);
    if (s >= 32) s -= 64;
    a = m_rf[ins[8:6]];
    b = m_rf[ins[5:3]];
    d = m_rf[ins[11:9]];
    res = '0;
    e.cycles = 3; e.wb_cyc = 0; e.addr = ins[11:9]; e.ovf = 1'b0;
    e.br = 0; e.ill = 0;
    case (op)
      0: begin full = to_s(a) + to_s(b); res = 16'(full); e.ovf = (full > 32767) || (full < -32768); end
      1: begin full = to_s(a) - to_s(b); res = 16'(full); e.ovf = (full > 32767) || (full < -32768); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin full = to_s(a) + s; res = 16'(full); e.ovf = (full > 32767) || (full < -32768); end
      6: begin addr = (int'(a) + s) & 63; res = m_mem[addr]; end
      7: begin addr = (int'(a) + s) & 63; m_mem[addr] = d; m_known[addr] = 1'b1; end
      8: e.br = (d == a) ? 1 : 0;
      default: e.ill = 1;
    endcase
    if (op <= 5) begin e.cycles = 4; e.wb_cyc = 3; end
    else if (op == 6) begin e.cycles = 5; e.wb_cyc = 4; end
    else if (op == 7) e.cycles = 4;
    e.data = res;
    if (e.wb_cyc != 0 && rd != 0) m_rf[rd] = res;
    m_pc = (e.br != 0) ? 8'(int'(m_pc) + 1 + s) : 8'(int'(m_pc) + 1);
    e.pc_after = m_pc;
  endtask

  // Called at a falling edge with the block idle; keeps instr_valid high until ready returns.
  task automatic run_instr(input logic [15:0] ins);
    exp_t e;
    int k, wb_n, br_n, ill_n, br_k, ill_k;
    bit done;
    model_step(ins, e);
    check("ready_at_offer", instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    k = 0; wb_n = 0; br_n = 0; ill_n = 0; br_k = 0; ill_k = 0; done = 0;
    last_wb_cyc = 0;
    while (!done && k < 12) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (wb_valid) begin
        wb_n++;
        last_wb_cyc  = k;
        last_wb_data = wb_data;
        last_wb_ovf  = ovf;
        check("wb_addr", wb_addr, e.addr);
      end
      if (take_branch) begin br_n++; br_k = k; end
      if (illegal) begin ill_n++; ill_k = k; end
      if (instr_ready) done = 1;
    end
    instr_valid = 1'b0;
    check("cycles", k, e.cycles);
    check("wb_count", wb_n, (e.wb_cyc != 0) ? 1 : 0);
    if (e.wb_cyc != 0) begin
      check("wb_cycle", last_wb_cyc, e.wb_cyc);
      check("wb_data", last_wb_data, e.data);
      check("wb_ovf", last_wb_ovf, e.ovf);
    end
    check("branch_count", br_n, e.br);
    if (e.br != 0) check("branch_cycle", br_k, 2);
    check("illegal_count", ill_n, e.ill);
    if (e.ill != 0) check("illegal_cycle", ill_k, 2);
    check("pc", pc, e.pc_after);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_pc", pc, 0);
    check("rst_wb_valid", wb_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] gen_instr();
    logic [15:0] w;
    int s, addr;
    w = 16'($urandom);
    if (w[15:12] >= 4'd9 && $urandom_range(0, 3) != 0) w[15:12] = 4'($urandom_range(0, 8));
    if (w[15:12] == 4'd6) begin
      s = int'(w[5:0]);
      if (s >= 32) s -= 64;
      addr = (int'(m_rf[w[8:6]]) + s) & 63;
      if (!m_known[addr]) w[15:12] = 4'd7;
    end
    return w;
  endfunction

  initial begin
    reset = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    model_reset();
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;

    @(negedge clk);
    check("init_ready", instr_ready, 1);
    check("init_pc", pc, 0);
    check("init_wb_valid", wb_valid, 0);
    check("init_ovf", ovf, 0);
    check("init_branch", take_branch, 0);
    check("init_illegal", illegal, 0);
    instr_valid = 1'b1;
    instr = enc_i(5, 1, 0, 6'd5);
    @(negedge clk);
    check("rst_hold_ready", instr_ready, 1);
    check("rst_hold_pc", pc, 0);
    instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // ADDI/ADDI/ADD basic sequence
    run_instr(enc_i(5, 1, 0, 6'd5));
    check("seq_wb0", last_wb_data, 16'h0005);
    run_instr(enc_i(5, 2, 0, 6'h3D));
    check("seq_wb1", last_wb_data, 16'hFFFD);
    run_instr(enc_r(0, 3, 1, 2));
    check("seq_wb2", last_wb_data, 16'h0002);
    check("seq_ovf", last_wb_ovf, 0);
    check("seq_pc", pc, 3);

    // r1 = 0x7FFF, then signed-overflowing ADD
    run_instr(enc_i(5, 1, 0, 6'd1));
    for (int i = 0; i < 15; i++) run_instr(enc_r(0, 1, 1, 1));
    run_instr(enc_i(5, 1, 1, 6'h3F));
    check("r1_7fff", last_wb_data, 16'h7FFF);
    run_instr(enc_r(0, 2, 1, 1));
    check("ovf_data", last_wb_data, 16'hFFFE);
    check("ovf_flag", last_wb_ovf, 1);

    // r1 = 0x1234, store to word 63, load back
    run_instr(enc_i(5, 1, 0, 6'd18));
    for (int i = 0; i < 8; i++) run_instr(enc_r(0, 1, 1, 1));
    run_instr(enc_i(5, 1, 1, 6'd31));
    run_instr(enc_i(5, 1, 1, 6'd21));
    check("r1_1234", last_wb_data, 16'h1234);
    run_instr(enc_i(7, 1, 0, 6'h3F));
    run_instr(enc_i(6, 4, 0, 6'h3F));
    check("lw63_data", last_wb_data, 16'h1234);
    check("lw63_cycle", last_wb_cyc, 4);

    // address 64 wraps to word 0
    run_instr(enc_i(5, 5, 0, 6'd31));
    run_instr(enc_i(5, 5, 5, 6'd31));
    run_instr(enc_i(5, 5, 5, 6'd2));
    check("r5_64", last_wb_data, 16'd64);
    run_instr(enc_i(7, 2, 5, 6'd0));
    run_instr(enc_i(6, 6, 0, 6'd0));
    check("wrap_lw0", last_wb_data, 16'hFFFE);

    // BEQ to itself at pc 0, then an illegal opcode
    do_reset();
    run_instr(enc_i(8, 0, 0, 6'h3F));
    check("beq_pc", pc, 0);
    run_instr(enc_r(15, 0, 0, 0));
    check("illegal_pc", pc, 1);

    // reset while wb_valid is high clears it without a clock edge
    run_instr(enc_i(5, 1, 0, 6'd20));
    instr = enc_r(0, 2, 1, 1);
    instr_valid = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("wb_before_rst", wb_valid, 1);
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    check("async_wb_valid", wb_valid, 0);
    check("async_ovf", ovf, 0);
    check("async_ready", instr_ready, 1);
    check("async_pc", pc, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run_instr(enc_r(0, 3, 2, 0));
    check("aborted_add", last_wb_data, 16'h0000);

    // reset in MEM of an LW with instr_valid held high
    instr = enc_i(6, 4, 0, 6'h3F);
    instr_valid = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("lw_in_mem", instr_ready, 0);
    reset = 1'b0;
    #1;
    check("mem_rst_wb", wb_valid, 0);
    check("mem_rst_pc", pc, 0);
    repeat (2) begin
      @(negedge clk);
      check("mem_rst_ready", instr_ready, 1);
      check("mem_rst_no_wb", wb_valid, 0);
    end
    instr_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    run_instr(enc_r(0, 5, 4, 0));
    check("r4_zero", last_wb_data, 16'h0000);
    run_instr(enc_i(6, 4, 0, 6'h3F));
    check("dmem_kept", last_wb_data, 16'h1234);

    // random instruction stream
    for (int n = 0; n < 250; n++) begin
      run_instr(gen_instr());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
